// File: rtl/dpram_port_arbiter.sv
// Two independent round-robin arbiters (write side, read side) in front of a dual-port RAM,
// with same-cycle write-to-read forwarding and a registered, tagged read response.
module dpram_port_arbiter #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w0_valid,
  input  logic [AW-1:0] w0_addr,
  input  logic [DW-1:0] w0_data,
  output logic          w0_ready,
  input  logic          w1_valid,
  input  logic [AW-1:0] w1_addr,
  input  logic [DW-1:0] w1_data,
  output logic          w1_ready,
  input  logic          r0_valid,
  input  logic [AW-1:0] r0_addr,
  output logic          r0_ready,
  input  logic          r1_valid,
  input  logic [AW-1:0] r1_addr,
  output logic          r1_ready,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] fwd_cnt
);

  logic          wptr, rptr;
  logic          w_gnt, w_id, r_gnt, r_id, fwd;
  logic          rsp_vld_q, rsp_id_q, fwd_q;
  logic [DW-1:0] fwd_data_q, hold_q;

  // pointer only breaks ties; a lone requester always wins
  always_comb begin
    w_gnt = ~reset & (w0_valid | w1_valid);
    w_id  = (w0_valid & w1_valid) ? wptr : w1_valid;
    r_gnt = ~reset & (r0_valid | r1_valid);
    r_id  = (r0_valid & r1_valid) ? rptr : r1_valid;
  end

  assign w0_ready  = w_gnt & ~w_id;
  assign w1_ready  = w_gnt & w_id;
  assign r0_ready  = r_gnt & ~r_id;
  assign r1_ready  = r_gnt & r_id;
  assign mem_we    = w_gnt;
  assign mem_waddr = w_id ? w1_addr : w0_addr;
  assign mem_wdata = w_id ? w1_data : w0_data;
  assign mem_re    = r_gnt;
  assign mem_raddr = r_id ? r1_addr : r0_addr;
  assign fwd       = w_gnt & r_gnt & (mem_waddr == mem_raddr);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      hold_q     <= '0;
      fwd_cnt    <= '0;
    end else begin
      if (w_gnt) wptr <= ~w_id;
      if (r_gnt) rptr <= ~r_id;
      rsp_vld_q <= r_gnt;
      if (r_gnt) begin
        rsp_id_q   <= r_id;
        fwd_q      <= fwd;
        fwd_data_q <= mem_wdata;
      end
      if (rsp_vld_q) hold_q <= rsp_data;
      if (fwd && fwd_cnt != {CW{1'b1}}) fwd_cnt <= fwd_cnt + 1'b1;
    end
  end

  // RAM data arrives combinationally in the response cycle, so the hold register
  // keeps rsp_data stable once the RAM output moves on; reset drops any pending response
  assign rsp_valid = rsp_vld_q & ~reset;
  assign rsp_id    = rsp_id_q & ~reset;
  assign rsp_data  = reset ? '0 : (rsp_vld_q ? (fwd_q ? fwd_data_q : mem_rdata) : hold_q);

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed vector table, reset-drop sequence,
// randomized traffic against a write-first memory model, forward counter saturation.
module tb_dpram_port_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       w0_valid, w1_valid, r0_valid, r1_valid;
  logic [3:0] w0_addr, w1_addr, r0_addr, r1_addr;
  logic [7:0] w0_data, w1_data;
  logic       w0_ready, w1_ready, r0_ready, r1_ready;
  logic       rsp_valid, rsp_id;
  logic [7:0] rsp_data;
  logic       mem_we, mem_re;
  logic [3:0] mem_waddr, mem_raddr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] fwd_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter #(.DW(8), .AW(4), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ready(w0_ready),
    .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ready(w1_ready),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .fwd_cnt(fwd_cnt)
  );

  // 16x8 dual-port RAM: registered read (old data on collision), clears on reset
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_re) mem_rdata <= ram[mem_raddr];
      if (mem_we) ram[mem_waddr] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;
    bit   [3:0] v;    // {w0,w1,r0,r1}
    logic [3:0] wa0, wa1, ra0, ra1;
    logic [7:0] wd0, wd1;
    bit   [3:0] rdy;  // {w0,w1,r0,r1}
    bit         rv, rid;
    logic [7:0] rd, fc;
  } vec_t;

  function automatic vec_t mk(bit rst, bit [3:0] v, logic [3:0] wa0, logic [7:0] wd0,
                              logic [3:0] wa1, logic [7:0] wd1, logic [3:0] ra0,
                              logic [3:0] ra1, bit [3:0] rdy, bit rv, bit rid,
                              logic [7:0] rd, logic [7:0] fc);
    vec_t t;
    t.rst = rst; t.v = v; t.wa0 = wa0; t.wd0 = wd0; t.wa1 = wa1; t.wd1 = wd1;
    t.ra0 = ra0; t.ra1 = ra1; t.rdy = rdy; t.rv = rv; t.rid = rid; t.rd = rd; t.fc = fc;
    return t;
  endfunction

  // behavioural reference: tie-break turn per side, write-first memory image
  logic [7:0] m_mem [16];
  bit         m_wturn, m_rturn, m_rv, m_rid;
  logic [7:0] m_rd;
  int         m_fwd;
  bit         g_w0, g_w1, g_r0, g_r1;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_wturn = 0; m_rturn = 0; m_rv = 0; m_rid = 0; m_rd = 8'h00; m_fwd = 0;
  endtask

  task automatic model_cycle();
    bit wg, wid, rg, rid;
    logic [3:0] wa, ra;
    logic [7:0] wd;
    wg  = w0_valid | w1_valid;
    wid = (w0_valid & w1_valid) ? m_wturn : w1_valid;
    rg  = r0_valid | r1_valid;
    rid = (r0_valid & r1_valid) ? m_rturn : r1_valid;
    wa  = wid ? w1_addr : w0_addr;
    wd  = wid ? w1_data : w0_data;
    ra  = rid ? r1_addr : r0_addr;
    g_w0 = wg & !wid; g_w1 = wg & wid; g_r0 = rg & !rid; g_r1 = rg & rid;
    chk("rnd_ready", {w0_ready, w1_ready, r0_ready, r1_ready}, {g_w0, g_w1, g_r0, g_r1});
    chk("rnd_mem_we", mem_we, wg);
    chk("rnd_mem_re", mem_re, rg);
    if (wg) chk("rnd_wfields", {mem_waddr, mem_wdata}, {wa, wd});
    if (rg) chk("rnd_raddr", mem_raddr, ra);
    chk("rnd_rsp_valid", rsp_valid, m_rv);
    chk("rnd_rsp_id", rsp_id, m_rid);
    chk("rnd_rsp_data", rsp_data, m_rd);
    chk("rnd_fwd_cnt", fwd_cnt, m_fwd);
    m_rv = rg;
    if (rg) begin
      m_rid = rid;
      m_rd  = (wg && wa == ra) ? wd : m_mem[ra];
      if (wg && wa == ra && m_fwd < 255) m_fwd++;
      m_rturn = !rid;
    end
    if (wg) begin
      m_mem[wa] = wd;
      m_wturn = !wid;
    end
  endtask

  task automatic idle_inputs();
    w0_valid = 0; w1_valid = 0; r0_valid = 0; r1_valid = 0;
    w0_addr = 0; w1_addr = 0; r0_addr = 0; r1_addr = 0; w0_data = 0; w1_data = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1; idle_inputs();
    @(negedge clk); reset = 0;
  endtask

  vec_t tbl [17];

  initial begin
    reset = 1; idle_inputs();
    tbl[0]  = mk(0, 4'b1000, 3, 8'hA5, 0, 0, 0, 0, 4'b1000, 0, 0, 8'h00, 0);
    tbl[1]  = mk(0, 4'b0010, 0, 0, 0, 0, 3, 0, 4'b0010, 0, 0, 8'h00, 0);
    tbl[2]  = mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 8'hA5, 0);
    tbl[3]  = mk(1, 4'b1111, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
    tbl[4]  = mk(0, 4'b1100, 0, 8'h10, 1, 8'h11, 0, 0, 4'b1000, 0, 0, 8'h00, 0);
    tbl[5]  = mk(0, 4'b1100, 2, 8'h12, 1, 8'h11, 0, 0, 4'b0100, 0, 0, 8'h00, 0);
    tbl[6]  = mk(0, 4'b1100, 2, 8'h12, 3, 8'h13, 0, 0, 4'b1000, 0, 0, 8'h00, 0);
    tbl[7]  = mk(0, 4'b1100, 2, 8'h12, 3, 8'h13, 0, 0, 4'b0100, 0, 0, 8'h00, 0);
    tbl[8]  = mk(0, 4'b0011, 0, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 8'h00, 0);
    tbl[9]  = mk(0, 4'b0011, 0, 0, 0, 0, 2, 1, 4'b0001, 1, 0, 8'h10, 0);
    tbl[10] = mk(0, 4'b0011, 0, 0, 0, 0, 2, 3, 4'b0010, 1, 1, 8'h11, 0);
    tbl[11] = mk(0, 4'b0011, 0, 0, 0, 0, 2, 3, 4'b0001, 1, 0, 8'h12, 0);
    tbl[12] = mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 8'h13, 0);
    tbl[13] = mk(0, 4'b1000, 5, 8'h11, 0, 0, 0, 0, 4'b1000, 0, 1, 8'h13, 0);
    tbl[14] = mk(0, 4'b0101, 0, 0, 5, 8'h3C, 0, 5, 4'b0101, 0, 1, 8'h13, 0);
    tbl[15] = mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 8'h3C, 1);
    tbl[16] = mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 8'h3C, 1);

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst;
      {w0_valid, w1_valid, r0_valid, r1_valid} = tbl[i].v;
      w0_addr = tbl[i].wa0; w0_data = tbl[i].wd0;
      w1_addr = tbl[i].wa1; w1_data = tbl[i].wd1;
      r0_addr = tbl[i].ra0; r1_addr = tbl[i].ra1;
      #1;
      chk($sformatf("vec%0d_ready", i), {w0_ready, w1_ready, r0_ready, r1_ready}, tbl[i].rdy);
      chk($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].rdy[3] | tbl[i].rdy[2]);
      chk($sformatf("vec%0d_mem_re", i), mem_re, tbl[i].rdy[1] | tbl[i].rdy[0]);
      chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, tbl[i].rv);
      chk($sformatf("vec%0d_rsp_id", i), rsp_id, tbl[i].rid);
      chk($sformatf("vec%0d_rsp_data", i), rsp_data, tbl[i].rd);
      chk($sformatf("vec%0d_fwd_cnt", i), fwd_cnt, tbl[i].fc);
    end

    // response pending when reset hits must vanish, and the RAM must come back cleared
    do_reset();
    @(negedge clk); idle_inputs(); w0_valid = 1; w0_addr = 7; w0_data = 8'h77;
    #1 chk("rst_drop_w0_ready", w0_ready, 1);
    @(negedge clk); idle_inputs(); r0_valid = 1; r0_addr = 7;
    #1 chk("rst_drop_r0_ready", r0_ready, 1);
    @(negedge clk); idle_inputs(); reset = 1;
    #1 chk("rst_drop_rsp_valid", rsp_valid, 0);
    @(negedge clk); reset = 0;
    #1 chk("rst_drop_rsp_valid_after", rsp_valid, 0);
    @(negedge clk); r0_valid = 1; r0_addr = 7;
    #1 chk("rst_reread_ready", r0_ready, 1);
    @(negedge clk); idle_inputs();
    #1 chk("rst_reread_valid", rsp_valid, 1);
    chk("rst_reread_data", rsp_data, 8'h00);

    // randomized traffic; ungranted requesters hold their request
    do_reset(); model_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!(w0_valid && !g_w0) || c == 0) begin
        w0_valid = $urandom_range(0, 1); w0_addr = 4'($urandom_range(0, 3)); w0_data = 8'($urandom);
      end
      if (!(w1_valid && !g_w1) || c == 0) begin
        w1_valid = $urandom_range(0, 1); w1_addr = 4'($urandom_range(0, 3)); w1_data = 8'($urandom);
      end
      if (!(r0_valid && !g_r0) || c == 0) begin
        r0_valid = $urandom_range(0, 1); r0_addr = 4'($urandom_range(0, 3));
      end
      if (!(r1_valid && !g_r1) || c == 0) begin
        r1_valid = $urandom_range(0, 1); r1_addr = 4'($urandom_range(0, 3));
      end
      #1 model_cycle();
    end

    // drive the forward counter into saturation
    do_reset(); model_reset();
    for (int c = 0; c < 262; c++) begin
      @(negedge clk);
      idle_inputs();
      w0_valid = 1; w0_addr = 9; w0_data = 8'(c);
      r0_valid = 1; r0_addr = 9;
      #1 model_cycle();
    end
    @(negedge clk); idle_inputs();
    #1 chk("fwd_cnt_saturated", fwd_cnt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
